uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

Parametrised word-sequence driver for the UART transmitter. Holds a writable buffer of `DEPTH` words of `DATA_W` bits and, on command, feeds them one at a time to the transmitter through the `tx_wr`/`tx_busy` handshake. Supports one-shot and loop modes, programmable sequence length, an acknowledge timeout, and an optional inter-word gap. Sits between host/control logic and `uart_transmitter`.

## Interface
- `DATA_W`, 8: word width; must match the transmitter's data width.
- `DEPTH`, 4: buffer entries, at least 2.
- `ACK_TIMEOUT`, 15: cycles to wait for `tx_busy` to rise after a strobe.
- `GAP_CYCLES`, 0: idle cycles between words. Used only with `UART_SEQ_GAP_EN`.
- `AW`: derived as `$clog2(DEPTH)`. It is not user-set.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle pulse that begins a sequence
- `stop`  in  1  single-cycle pulse requesting a stop after the current word
- `loop_mode`  in  1  1 means wrap and repeat; sampled together with `start`
- `num_words`  in  AW+1  sequence length, sampled with `start`; 0 or any value >DEPTH means DEPTH
- `buf_we`  in  1  buffer write enable
- `buf_addr`  in  AW  buffer write address
- `buf_wdata`  in  DATA_W  buffer write data
- `tx_busy`  in  1  transmitter busy
- `tx_wr`  out  1  one-cycle write strobe to the transmitter
- `tx_data`  out  DATA_W  word presented to the transmitter
- `active`  out  1  high in every state other than IDLE
- `done`  out  1  one-cycle pulse when a sequence ends normally
- `ack_err`  out  1  sticky flag set on ack timeout; cleared by reset or by the next accepted `start`
- `word_idx`  out  AW  index of the word currently being sent

## Operation
**Reset values**
- Buffer entry i resets to `SEQ_PATTERN[i % 4]` = AA, 55, CC, 89.
- State resets to IDLE.
- `tx_wr`=0, `tx_data`=`SEQ_PATTERN[0]`, `active`=0, `done`=0, `ack_err`=0, `word_idx`=0.

**FSM**
- IDLE:
  - On `start`, latch the effective length L and `loop_mode`, set `word_idx`=0, go to STROBE.
- STROBE:
  - Register `tx_data`=buf[`word_idx`] and `tx_wr`=1 for exactly one cycle.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - `tx_wr`=0.
  - When `tx_busy`=1, go to WAIT_DONE.
  - If `tx_busy` stays low for ACK_TIMEOUT cycles: set `ack_err`, go to IDLE, no `done`.
- WAIT_DONE:
  - When `tx_busy`=0, go to GAP (if the macro is defined and GAP_CYCLES>0) or to NEXT.
- GAP:
  - Count down GAP_CYCLES, then go to NEXT.
- NEXT:
  - If a stop is pending, go to IDLE and pulse `done`.
  - Else if `word_idx`==L-1:
    - in loop mode, set `word_idx`=0 and go to STROBE;
    - otherwise, pulse `done` and go to IDLE.
  - Else increment `word_idx` and go to STROBE.

**Boundary rules**
- `start` while `active` is ignored.
- `stop` in any non-IDLE state sets a pending flag.
  - The current word always completes.
  - The flag clears on entering IDLE.
- `stop` in IDLE has no effect.
- `buf_we` is always honoured, including mid-sequence. Because `tx_data` is captured at STROBE, a write to the entry in flight affects only later passes.
- `start` and `buf_we` to entry 0 in the same cycle: the new data is sent, because the write lands before STROBE.
- Reset mid-operation returns everything immediately to the reset values, buffer contents included.

## Timing
- `start` is sampled at edge k. At edge k+1, `tx_wr`=1 and `tx_data` is valid. At edge k+2, `tx_wr`=0.
- `tx_data` is held stable from STROBE until the next STROBE.
- `tx_wr` is never asserted while `tx_busy`=1. It is never asserted on two consecutive cycles.
- Minimum gap from `tx_busy` falling to the next `tx_wr` is 2 cycles (WAIT_DONE, then NEXT), plus GAP_CYCLES when the gap is enabled.
- `done` is asserted in the same cycle the FSM enters IDLE. `active` falls on that same edge.

## Configuration
`UART_SEQ_GAP_EN`
- **Defined:** the GAP state and its `$clog2(GAP_CYCLES+1)`-bit counter are built in, and GAP_CYCLES idle cycles are inserted after every word, including the last word before loop wrap.
- **Undefined:** there is no GAP state, GAP_CYCLES is ignored, and WAIT_DONE goes directly to NEXT.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding;
  - `SEQ_PATTERN[0:3]`;
  - the default `DATA_W`.
- One sub-module, `uart_seq_buf`: a DEPTH×DATA_W register file with a synchronous write port, an asynchronous read port, and async-reset initialisation to the pattern.
- FSM, counters and flags live in `uart_tx_sequencer`.

## Test plan
- **Reset pattern:** after reset, `start` with `num_words`=0, DEPTH=4, and a transmitter model that raises busy 1 cycle after the strobe and holds it 20 cycles → `tx_data` sequence AA, 55, CC, 89; four `tx_wr` pulses; one `done`; `active` low afterwards.
- **Loop with stop:** `loop_mode`=1, `num_words`=2 → AA, 55, AA, 55, …; `stop` during the 3rd word → exactly 3 words sent, then `done`.
- **Ack timeout:** `tx_busy` tied 0 → one `tx_wr`, then `ack_err`=1 and `active`=0 ACK_TIMEOUT+2 cycles after `start`, and no `done`.
- **Mid-sequence write:** write 3C to entry 2 while word 1 is in flight → third word sent is 3C. A write to entry 1 in the same window leaves the word in flight as 55.
- **Gap (`UART_SEQ_GAP_EN`, GAP_CYCLES=5):** busy-fall to next `tx_wr` = 7 cycles. With the macro undefined: 2 cycles.
- **Reset mid-word:** assert `reset` during WAIT_DONE → `tx_wr`=0, `active`=0, buffer restored to AA/55/CC/89; a subsequent `start` sends AA.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer state encoding and reset pattern.
// The GAP state exists only when UART_SEQ_GAP_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic [7:0] SEQ_PATTERN [0:3] = '{8'hAA, 8'h55, 8'hCC, 8'h89};

`ifdef UART_SEQ_GAP_EN
  typedef enum logic [2:0] {
    StIdle, StStrobe, StWaitAck, StWaitDone, StGap, StNext
  } seq_state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StStrobe, StWaitAck, StWaitDone, StNext
  } seq_state_e;
`endif

  // Reset value of buffer entry idx; the pattern repeats every four entries.
  function automatic logic [7:0] seq_pattern(input int unsigned idx);
    logic [1:0] sel;
    sel = 2'(idx % 4);
    return SEQ_PATTERN[sel];
  endfunction

endpackage

// File: rtl/uart_seq_buf.sv
// Word buffer for the TX sequencer: synchronous write, asynchronous read,
// entries reset to the repeating seq_pattern.
module uart_seq_buf
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(seq_pattern(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_sequencer.sv
// Feeds buffered words to the UART transmitter over the tx_wr/tx_busy handshake.
// Define UART_SEQ_GAP_EN to insert GAP_CYCLES idle cycles after every word.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned GAP_CYCLES  = 0,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [AW:0]       num_words,
  input  logic              buf_we,
  input  logic [AW-1:0]     buf_addr,
  input  logic [DATA_W-1:0] buf_wdata,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [DATA_W-1:0] tx_data,
  output logic              active,
  output logic              done,
  output logic              ack_err,
  output logic [AW-1:0]     word_idx
);

  localparam int unsigned AckW    = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [AW:0] FullLen = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LenOne  = (AW + 1)'(1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     word_idx_q, word_idx_d;
  logic [AW:0]       len_q, len_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic [AckW-1:0]   ack_cnt_q, ack_cnt_d;
  logic              tx_wr_q, tx_wr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic [DATA_W-1:0] buf_rdata;
  logic              last_word;

`ifdef UART_SEQ_GAP_EN
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  uart_seq_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (buf_we),
    .waddr_i (buf_addr),
    .wdata_i (buf_wdata),
    .raddr_i (word_idx_q),
    .rdata_o (buf_rdata)
  );

  assign last_word = (({1'b0, word_idx_q} + LenOne) == len_q);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    loop_d     = loop_q;
    stop_d     = stop_q;
    ack_cnt_d  = ack_cnt_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
`ifdef UART_SEQ_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    if (stop && (state_q != StIdle)) begin
      stop_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if ((num_words == '0) || (32'(num_words) > DEPTH)) begin
            len_d = FullLen;
          end else begin
            len_d = num_words;
          end
          loop_d     = loop_mode;
          word_idx_d = '0;
          ack_err_d  = 1'b0;
          state_d    = StStrobe;
        end
      end
      StStrobe: begin
        // Data is captured here, so buffer writes after this point hit only later passes.
        tx_data_d = buf_rdata;
        tx_wr_d   = 1'b1;
        ack_cnt_d = '0;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (ack_cnt_q == AckW'(ACK_TIMEOUT)) begin
          ack_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
`ifdef UART_SEQ_GAP_EN
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GapW'(GAP_CYCLES);
            state_d   = StGap;
          end else begin
            state_d = StNext;
          end
`else
          state_d = StNext;
`endif
        end
      end
`ifdef UART_SEQ_GAP_EN
      StGap: begin
        if (gap_cnt_q <= GapW'(1)) begin
          state_d = StNext;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
`endif
      StNext: begin
        if (stop_q || stop) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (last_word) begin
          if (loop_q) begin
            word_idx_d = '0;
            state_d    = StStrobe;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          word_idx_d = word_idx_q + AW'(1);
          state_d    = StStrobe;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      len_q      <= FullLen;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      ack_cnt_q  <= '0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= DATA_W'(seq_pattern(0));
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
`ifdef UART_SEQ_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      stop_q     <= stop_d;
      ack_cnt_q  <= ack_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
`ifdef UART_SEQ_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign tx_wr    = tx_wr_q;
  assign tx_data  = tx_data_q;
  assign active   = (state_q != StIdle);
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign word_idx = word_idx_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: a transmitter model plus a scoreboard of
// expected tx_data words checked on every tx_wr strobe.
module tb_uart_tx_sequencer;

  localparam int unsigned AckTimeout = 15;
  localparam int unsigned GapCycles  = 5;
  localparam int          BusyLen    = 20;
`ifdef UART_SEQ_GAP_EN
  localparam int ExpGap = 2 + GapCycles;
`else
  localparam int ExpGap = 2;
`endif

  logic       clk = 1'b0;
  logic       reset, start, stop, loop_mode;
  logic [2:0] num_words;
  logic       buf_we;
  logic [1:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       tx_busy = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       active, done, ack_err;
  logic [1:0] word_idx;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int wr_cnt = 0, done_cnt = 0;
  int cyc = 0, fall_cyc = 0, last_gap = -1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  bit xmit_en = 1'b1;
  bit pend = 1'b0;
  bit prev_wr = 1'b0;
  int bcnt = 0;

  uart_tx_sequencer #(
    .DATA_W      (8),
    .DEPTH       (4),
    .ACK_TIMEOUT (AckTimeout),
    .GAP_CYCLES  (GapCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .num_words (num_words),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .tx_busy   (tx_busy),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .active    (active),
    .done      (done),
    .ack_err   (ack_err),
    .word_idx  (word_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor first, then advance the transmitter model, so both see the same busy value.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (tx_wr === 1'b1) begin
        wr_cnt++;
        check("wr_while_busy", tx_busy, 0);
        check("wr_back_to_back", prev_wr, 0);
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("tx_data", tx_data, exp_w);
        end
        last_gap = cyc - fall_cyc;
      end
      if (done === 1'b1) done_cnt++;
    end
    prev_wr = (tx_wr === 1'b1);

    if (reset === 1'b1 || !xmit_en) begin
      tx_busy = 1'b0;
      pend    = 1'b0;
      bcnt    = 0;
    end else begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cyc + 1;
        end
      end else if (pend) begin
        tx_busy = 1'b1;
        bcnt    = BusyLen;
        pend    = 1'b0;
      end
      if (tx_wr === 1'b1) pend = 1'b1;
    end
  end

  task automatic start_seq(input logic [2:0] nw, input logic lm);
    num_words = nw;
    loop_mode = lm;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, active, 0);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (wr_cnt < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, wr_cnt >= target, 1);
  endtask

  task automatic clear_counts();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0; num_words = '0;
    buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 8'hAA);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_word_idx", word_idx, 0);

    // Reset pattern, full length, with strobe timing
    clear_counts();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    exp_q.push_back(8'hCC); exp_q.push_back(8'h89);
    start_seq(3'd0, 1'b0);
    check("k_active", active, 1);
    check("k_no_wr", tx_wr, 0);
    @(negedge clk);
    check("k1_wr", tx_wr, 1);
    check("k1_data", tx_data, 8'hAA);
    @(negedge clk);
    check("k2_wr", tx_wr, 0);
    wait_idle("rp_idle");
    check("rp_words", wr_cnt, 4);
    check("rp_done", done_cnt, 1);
    check("rp_sb_empty", exp_q.size(), 0);
    check("rp_gap", last_gap, ExpGap);

    // Loop of two words, stop during the third word
    clear_counts();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    start_seq(3'd2, 1'b1);
    wait_wr(3, "loop_third_word");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("loop_idle");
    check("loop_words", wr_cnt, 3);
    check("loop_done", done_cnt, 1);
    check("loop_sb_empty", exp_q.size(), 0);

    // Ack timeout with busy tied low
    xmit_en = 1'b0;
    @(negedge clk);
    clear_counts();
    exp_q.push_back(8'hAA);
    start_seq(3'd1, 1'b0);
    repeat (AckTimeout + 1) @(negedge clk);
    check("to_active_before", active, 1);
    check("to_err_before", ack_err, 0);
    @(negedge clk);
    check("to_err", ack_err, 1);
    check("to_active_after", active, 0);
    @(negedge clk);
    check("to_no_done", done_cnt, 0);
    check("to_one_wr", wr_cnt, 1);
    xmit_en = 1'b1;

    // Mid-sequence writes to entries 2 and 1 while word 1 is in flight
    clear_counts();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h89);
    start_seq(3'd0, 1'b0);
    check("err_cleared_on_start", ack_err, 0);
    wait_wr(2, "mid_second_word");
    buf_we = 1'b1; buf_addr = 2'd2; buf_wdata = 8'h3C;
    @(negedge clk);
    buf_addr = 2'd1; buf_wdata = 8'h11;
    @(negedge clk);
    buf_we = 1'b0;
    wait_idle("mid_idle");
    check("mid_words", wr_cnt, 4);
    check("mid_sb_empty", exp_q.size(), 0);

    // Start together with a write to entry 0: new data goes out
    clear_counts();
    exp_q.push_back(8'h5A);
    buf_we = 1'b1; buf_addr = 2'd0; buf_wdata = 8'h5A;
    start_seq(3'd1, 1'b0);
    buf_we = 1'b0;
    wait_idle("same_idle");
    check("same_words", wr_cnt, 1);
    check("same_sb_empty", exp_q.size(), 0);

    // Reset during WAIT_DONE restores outputs and buffer contents
    clear_counts();
    exp_q.push_back(8'h5A);
    start_seq(3'd0, 1'b0);
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rmw_busy_seen", tx_busy, 1);
    reset = 1'b1;
    #1;
    check("rmw_tx_wr", tx_wr, 0);
    check("rmw_active", active, 0);
    check("rmw_tx_data", tx_data, 8'hAA);
    check("rmw_word_idx", word_idx, 0);
    check("rmw_first_sent", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    clear_counts();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    exp_q.push_back(8'hCC); exp_q.push_back(8'h89);
    start_seq(3'd0, 1'b0);
    wait_idle("post_rst_idle");
    check("post_rst_words", wr_cnt, 4);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

endmodule
